mem_dma: RTL

Single-channel memory-copy engine that acts as an initiator on the core's valid/ready memory bus (mem_valid, mem_ready, mem_addr, mem_rdata, mem_wdata, mem_wstrb). Software loads source, destination and word count, pulses start, and the block copies the words one transaction at a time into any responder on that bus, such as the on-chip word RAM. It sits beside the CPU behind the bus arbiter and is the bus-master counterpart to the memory responders.

---
 rtl/mem_dma_pkg.sv | 28 ++
 rtl/mem_bus_xact.sv | 60 ++++++
 rtl/mem_dma.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mem_dma_pkg.sv
// ============================================================================
// Module  : mem_dma_pkg
// Brief   : shared state encoding and bus constants for the mem_dma engine
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_dma_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_READ  = 3'd1;
    localparam state_t S_WRITE = 3'd2;
    localparam state_t S_GAP   = 3'd3;
    localparam state_t S_DONE  = 3'd4;

    localparam logic [3:0]  WSTRB_NONE = 4'b0000;
    localparam logic [3:0]  WSTRB_ALL  = 4'b1111;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_bus_xact.sv
// ============================================================================
// Module  : mem_bus_xact
// Brief   : single-transaction initiator; holds the request on the bus until
//           the responder acknowledges with mem_ready
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_bus_xact
    import mem_dma_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb
);

    logic        r_valid;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;

    // mem_ready outside an active request is not an acknowledge
    assign ack   = r_valid & mem_ready;
    assign rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= WSTRB_NONE;
        end else if (req) begin
            r_valid <= 1'b1;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_wstrb <= req_write ? WSTRB_ALL : WSTRB_NONE;
        end else if (ack) begin
            r_valid <= 1'b0;
        end
    end

    assign mem_valid = r_valid;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_wstrb = r_wstrb;

endmodule

`default_nettype wire

// File: rtl/mem_dma.sv
// ============================================================================
// Module  : mem_dma
// Brief   : single-channel word copy engine on the valid/ready memory bus;
//           define MEM_DMA_FILL_EN to add a constant-fill mode
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_dma
    import mem_dma_pkg::*;
#(
    parameter int LEN_W = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
`ifdef MEM_DMA_FILL_EN
    input  logic             fill,
    input  logic [31:0]      fill_data,
`endif
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] words_done,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic [31:0]      mem_addr,
    input  logic [31:0]      mem_rdata,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb
);

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic [LEN_W-1:0] r_words_done;
    logic [LEN_W-1:0] r_len;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [31:0]      r_data;
    logic             r_to_write;
    logic             r_fill;
    logic [31:0]      r_fill_data;

    logic             w_start_fill;
    logic [31:0]      w_start_fill_data;
    logic             w_req;
    logic             w_req_write;
    logic [31:0]      w_req_addr;
    logic [31:0]      w_req_wdata;
    logic             w_ack;
    logic [31:0]      w_rdata;
    logic [LEN_W-1:0] w_words_next;

`ifdef MEM_DMA_FILL_EN
    assign w_start_fill      = fill;
    assign w_start_fill_data = fill_data;
`else
    assign w_start_fill      = 1'b0;
    assign w_start_fill_data = '0;
`endif

    assign w_words_next = r_words_done + {{(LEN_W-1){1'b0}}, 1'b1};

    // Requests are issued on the edge leaving IDLE or GAP so mem_valid is
    // already high in the first READ/WRITE cycle.
    always_comb begin
        w_req       = 1'b0;
        w_req_write = 1'b0;
        w_req_addr  = r_src;
        w_req_wdata = r_data;
        case (r_state)
            S_IDLE: begin
                if (start && (len != '0)) begin
                    w_req       = 1'b1;
                    w_req_write = w_start_fill;
                    w_req_addr  = w_start_fill ? word_align(dst_addr) : word_align(src_addr);
                    w_req_wdata = w_start_fill_data;
                end
            end
            S_GAP: begin
                w_req       = 1'b1;
                w_req_write = r_to_write;
                w_req_addr  = r_to_write ? r_dst : r_src;
                w_req_wdata = r_fill ? r_fill_data : r_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_words_done <= '0;
            r_len        <= '0;
            r_src        <= '0;
            r_dst        <= '0;
            r_data       <= '0;
            r_to_write   <= 1'b0;
            r_fill       <= 1'b0;
            r_fill_data  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            r_src        <= word_align(src_addr);
                            r_dst        <= word_align(dst_addr);
                            r_len        <= len;
                            r_words_done <= '0;
                            r_fill       <= w_start_fill;
                            r_fill_data  <= w_start_fill_data;
                            r_to_write   <= w_start_fill;
                            r_busy       <= 1'b1;
                            r_state      <= w_start_fill ? S_WRITE : S_READ;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_READ: begin
                    if (w_ack) begin
                        r_data     <= w_rdata;
                        r_to_write <= 1'b1;
                        r_state    <= S_GAP;
                    end
                end
                S_WRITE: begin
                    if (w_ack) begin
                        r_src        <= r_src + WORD_BYTES;
                        r_dst        <= r_dst + WORD_BYTES;
                        r_words_done <= w_words_next;
                        if (w_words_next == r_len) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_to_write <= r_fill;
                            r_state    <= S_GAP;
                        end
                    end
                end
                S_GAP:   r_state <= r_to_write ? S_WRITE : S_READ;
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    mem_bus_xact u_xact (
        .clk       (clk),
        .rst       (rst),
        .req       (w_req),
        .req_write (w_req_write),
        .req_addr  (w_req_addr),
        .req_wdata (w_req_wdata),
        .ack       (w_ack),
        .rdata     (w_rdata),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb)
    );

    assign busy       = r_busy;
    assign done       = r_done;
    assign words_done = r_words_done;

endmodule

`default_nettype wire
